// File: rtl/red_seq_16bit_pkg.sv
// Shared RED result-width constants. The combinational and the sequenced RED
// variants both use them.
package red_seq_16bit_pkg;
  localparam int RED_SIG_W = 9;
  localparam int RED_EXT_W = 7;
  localparam int RED_OUT_W = RED_SIG_W + RED_EXT_W;
endpackage

// File: rtl/cla_adder_4bit.sv
// 4-bit carry-lookahead adder slice. All carries are computed in parallel
// from the generate/propagate terms.
module cla_adder_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout,
  output logic       o_ovfl
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:1] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum  = w_p ^ {w_c[3:1], i_cin};
  assign o_cout = w_c[4];
  // Signed overflow of the slice: carry into the MSB differs from carry out.
  assign o_ovfl = w_c[4] ^ w_c[3];
endmodule

// File: rtl/red_seq_16bit.sv
// Sequenced byte-reduction unit: adds the four bytes of two 16-bit operands
// using one shared 4-bit CLA stepped through seven cycles.
module red_seq_16bit
  import red_seq_16bit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 flush,
  input  logic [15:0]          a_in,
  input  logic [15:0]          b_in,
  output logic                 busy,
  output logic                 done,
  output logic [RED_OUT_W-1:0] sum_out
);
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_L0   = 3'd1,
    ST_L1   = 3'd2,
    ST_U0   = 3'd3,
    ST_U1   = 3'd4,
    ST_F0   = 3'd5,
    ST_F1   = 3'd6,
    ST_F2   = 3'd7
  } state_e;

  state_e               r_state;
  logic [15:0]          r_opa;
  logic [15:0]          r_opb;
  logic [8:0]           r_s0;
  logic [8:0]           r_s1;
  logic [7:0]           r_fin_lo;
  logic                 r_c;
  logic                 r_done;
  logic [RED_OUT_W-1:0] r_sum_out;

  logic [3:0] w_add_a;
  logic [3:0] w_add_b;
  logic       w_add_cin;
  logic [3:0] w_sum;
  logic       w_cout;
  logic       w_unused_ovfl;

  // NOTE: every signal driven here gets a default first, so no state leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_add_a   = 4'd0;
    w_add_b   = 4'd0;
    w_add_cin = 1'b0;
    unique case (r_state)
      ST_IDLE: ;
      ST_L0: begin w_add_a = r_opa[3:0];   w_add_b = r_opb[3:0];                    end
      ST_L1: begin w_add_a = r_opa[7:4];   w_add_b = r_opb[7:4];   w_add_cin = r_c; end
      ST_U0: begin w_add_a = r_opa[11:8];  w_add_b = r_opb[11:8];                   end
      ST_U1: begin w_add_a = r_opa[15:12]; w_add_b = r_opb[15:12]; w_add_cin = r_c; end
      ST_F0: begin w_add_a = r_s0[3:0];    w_add_b = r_s1[3:0];                     end
      ST_F1: begin w_add_a = r_s0[7:4];    w_add_b = r_s1[7:4];    w_add_cin = r_c; end
      ST_F2: begin
        w_add_a   = {3'b000, r_s0[8]};
        w_add_b   = {3'b000, r_s1[8]};
        w_add_cin = r_c;
      end
      default: ;
    endcase
  end

  cla_adder_4bit u_adder (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (w_add_cin),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_ovfl (w_unused_ovfl)
  );

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_opa     <= '0;
      r_opb     <= '0;
      r_s0      <= '0;
      r_s1      <= '0;
      r_fin_lo  <= '0;
      r_c       <= 1'b0;
      r_done    <= 1'b0;
      r_sum_out <= '0;
    end else begin
      r_done <= 1'b0;
      // Flush wins over sequencing; in IDLE it also masks a coincident start.
      if (flush) begin
        r_state <= ST_IDLE;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_opa   <= a_in;
              r_opb   <= b_in;
              r_state <= ST_L0;
            end
          end
          ST_L0: begin
            r_s0[3:0] <= w_sum;
            r_c       <= w_cout;
            r_state   <= ST_L1;
          end
          ST_L1: begin
            r_s0[8:4] <= {w_cout, w_sum};
            r_state   <= ST_U0;
          end
          ST_U0: begin
            r_s1[3:0] <= w_sum;
            r_c       <= w_cout;
            r_state   <= ST_U1;
          end
          ST_U1: begin
            r_s1[8:4] <= {w_cout, w_sum};
            r_state   <= ST_F0;
          end
          ST_F0: begin
            r_fin_lo[3:0] <= w_sum;
            r_c           <= w_cout;
            r_state       <= ST_F1;
          end
          ST_F1: begin
            r_fin_lo[7:4] <= w_sum;
            r_c           <= w_cout;
            r_state       <= ST_F2;
          end
          ST_F2: begin
            // w_sum[0] is fin[8]; fin[11:9] are dropped by design.
            r_sum_out <= {{RED_EXT_W{w_sum[0]}}, w_sum[0], r_fin_lo};
            r_done    <= 1'b1;
            r_state   <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  assign sum_out = r_sum_out;
endmodule

// File: tb/tb_red_seq_16bit.sv
// Scoreboard bench for red_seq_16bit: directed plan cases plus random issue,
// checked against a plain-arithmetic byte-sum model.
module tb_red_seq_16bit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        busy;
  logic        done;
  logic [15:0] sum_out;

  red_seq_16bit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .flush   (flush),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] exp;
    int          acc;
  } sb_entry_t;

  sb_entry_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Sum of all four bytes, keep nine significant bits, sign-extend bit 8.
  function automatic logic [15:0] ref_red(input logic [15:0] a, input logic [15:0] b);
    int unsigned total;
    logic [8:0]  f;
    total = 32'(a[7:0]) + 32'(b[7:0]) + 32'(a[15:8]) + 32'(b[15:8]);
    f = total[8:0];
    return {{7{f[8]}}, f};
  endfunction

  // Monitor: compare every done against the oldest expectation.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        check("done_width", 16'(prev_done), 16'd0);
        check("busy_at_done", 16'(busy), 16'd0);
        if (sb.size() == 0) begin
          check("unexpected_done", 16'(done), 16'd0);
        end else begin
          sb_entry_t e;
          e = sb.pop_front();
          check("sum_out", sum_out, e.exp);
          check("latency", 16'(cyc - e.acc), 16'd7);
        end
      end
      prev_done <= done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  // Waits for idle, pulses start, returns #1 after the accept edge (busy cycle 1).
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit push);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (busy) check("issue_timeout", 16'(busy), 16'd0);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    @(posedge clk);
    #1;
    if (push) sb.push_back('{exp: ref_red(a, b), acc: cyc});
    start = 1'b0;
    a_in  = 16'($urandom);
    b_in  = 16'($urandom);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((busy || sb.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", 16'(guard < 100), 16'd1);
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    bit          got;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_sum", sum_out, 16'h0000);
    rst = 1'b0;

    // Basic case with explicit busy-run length.
    issue(16'h0102, 16'h0304, 1'b1);
    for (int i = 0; i < 7; i++) begin
      check("busy_run", 16'(busy), 16'd1);
      @(posedge clk);
      #1;
    end
    check("busy_end", 16'(busy), 16'd0);
    check("done_pulse", 16'(done), 16'd1);
    check("basic_sum", sum_out, 16'h000A);
    wait_drain();

    issue(16'h7F7F, 16'h0101, 1'b1);
    wait_drain();
    check("sign_ext", sum_out, 16'hFF00);
    issue(16'hFFFF, 16'hFFFF, 1'b1);
    wait_drain();
    check("saturate", sum_out, 16'hFFFC);

    // Back-to-back: start held through busy and the done cycle.
    issue(16'h0102, 16'h0304, 1'b1);
    start = 1'b1;
    a_in  = 16'h7F7F;
    b_in  = 16'h0101;
    got   = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done) begin
        @(posedge clk);
        #1;
        sb.push_back('{exp: 16'hFF00, acc: cyc});
        start = 1'b0;
        got = 1'b1;
        check("b2b_accept_busy", 16'(busy), 16'd1);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    check("b2b_seen_done", 16'(got), 16'd1);
    wait_drain();
    check("b2b_sum", sum_out, 16'hFF00);

    // Flush in F1 with sum_out holding 000A.
    issue(16'h0102, 16'h0304, 1'b1);
    wait_drain();
    issue(16'hFFFF, 16'hFFFF, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("pre_flush_busy", 16'(busy), 16'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", 16'(busy), 16'd0);
    check("flush_done", 16'(done), 16'd0);
    check("flush_sum", sum_out, 16'h000A);
    repeat (10) @(posedge clk);
    #1;
    check("flush_sum_hold", sum_out, 16'h000A);

    // Flush and start together in IDLE: nothing captured.
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    a_in  = 16'hFFFF;
    b_in  = 16'hFFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check("flush_start_busy", 16'(busy), 16'd0);
    repeat (9) @(posedge clk);
    #1;
    check("flush_start_sum", sum_out, 16'h000A);

    // Reset in U1.
    issue(16'h1234, 16'h5678, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rstmid_busy", 16'(busy), 16'd0);
    check("rstmid_done", 16'(done), 16'd0);
    check("rstmid_sum", sum_out, 16'h0000);
    repeat (9) @(posedge clk);
    #1;
    check("rstmid_no_done_sum", sum_out, 16'h0000);
    issue(16'h0102, 16'h0304, 1'b1);
    wait_drain();
    check("post_rst_sum", sum_out, 16'h000A);

    // Random issue, mix of back-to-back and spaced requests.
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ((i % 7) == 0) ra = 16'hFFFF;
      if ((i % 5) == 0) rb = 16'h0000;
      issue(ra, rb, 1'b1);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 12)) @(posedge clk);
    end
    wait_drain();
    check("sb_empty", 16'(sb.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
